// File: rtl/spi_frame_pkg.sv
// Shared constants for the 192-bit SPI display frame plus the receiver state set.
// Latency: none, declarations only.
// Backpressure: none; the SPI link has no flow control.
package spi_frame_pkg;

  localparam int FRAME_BITS = 192;
  localparam int PAGE_BITS  = 128;
  localparam int PTR_BITS   = 16;
  localparam int LAST_BITS  = 48;

  // Bit offsets inside the shadow register once a whole frame has been shifted in
  localparam int PTR_LSB    = LAST_BITS;
  localparam int SIZE_LSB   = LAST_BITS + 8;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PAGE,
    POINTERS,
    LAST,
    OVERRUN,
    COMMIT
  } rx_state_t;

endpackage

// File: rtl/spi_frame_receiver_if.sv
// Pin-side SPI inputs and registered frame outputs of the display-frame receiver.
// Latency: none, wiring only.
// Backpressure: none; outputs are held until the next good frame.
interface spi_frame_receiver_if #(
  parameter int page     = 16,
  parameter int depth    = 32,
  parameter int width    = 8,
  parameter int newWidth = 44
);

  localparam int PW = $clog2(depth + 1);

  logic                       sclk;
  logic                       mosi;
  logic                       cs;
  logic [page-1:0][width-1:0] rxPage;
  logic [PW-1:0]              rxSize;
  logic [PW-1:0]              rxPtr;
  logic                       rxPageSel;
  logic [newWidth-1:0]        rxAnswer;
  logic                       frameValid;
  logic                       frameError;
  logic                       busy;

  modport master (
    output sclk, mosi, cs,
    input  rxPage, rxSize, rxPtr, rxPageSel, rxAnswer, frameValid, frameError, busy
  );

  modport slave (
    input  sclk, mosi, cs,
    output rxPage, rxSize, rxPtr, rxPageSel, rxAnswer, frameValid, frameError, busy
  );

endinterface

// File: rtl/spi_rx_sync.sv
// Synchronises sclk/mosi/cs into the clock domain and flags sclk rise, cs rise/fall.
// Latency: SYNC_STAGES clocks to the synchronised level, edge flags combinational on it.
// Backpressure: none; every pin change is sampled.
module spi_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_sclk,
  input  logic i_mosi,
  input  logic i_cs,
  output logic o_mosi,
  output logic o_cs,
  output logic o_sclk_rise,
  output logic o_cs_rise,
  output logic o_cs_fall
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  // Shift chains reset to 0 so cs reads low after reset and only a real high re-arms
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign o_cs        = r_cs_sync[SYNC_STAGES-1];
  assign o_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign o_cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;
  assign o_cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_prev;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave deserialising the 192-bit display frame into held registered fields.
// Latency: frameValid/frameError pulse SYNC_STAGES+2 clocks after the pin-level cs rise.
// Backpressure: none; optional SPI_RX_FRAME_CHECK_EN also rejects bad reserved bits / ptr > size.
module spi_frame_receiver
  import spi_frame_pkg::*;
#(
  parameter int page        = 16,
  parameter int depth       = 32,
  parameter int width       = 8,
  parameter int newWidth    = 44,
  parameter int SYNC_STAGES = 2
) (
  input logic                  clock,
  input logic                  reset,
  spi_frame_receiver_if.slave  bus
);

  localparam int         PW       = $clog2(depth + 1);
  localparam logic [7:0] CNT_FULL = 8'(FRAME_BITS);
  localparam logic [7:0] CNT_PAGE = 8'(PAGE_BITS);
  localparam logic [7:0] CNT_PTRS = 8'(PAGE_BITS + PTR_BITS);

  logic w_mosi, w_cs, w_sclk_rise, w_cs_rise, w_cs_fall;
  logic w_len_ok, w_chk_ok;
  logic [7:0] w_next_cnt;

  rx_state_t                  r_state;
  logic [7:0]                 r_bit_cnt;
  logic [FRAME_BITS-1:0]      r_shadow;
  logic [page-1:0][width-1:0] r_page;
  logic [PW-1:0]              r_size;
  logic [PW-1:0]              r_ptr;
  logic                       r_page_sel;
  logic [newWidth-1:0]        r_answer;
  logic                       r_frame_valid;
  logic                       r_frame_error;
  logic                       r_busy;

  spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_sclk      (bus.sclk),
    .i_mosi      (bus.mosi),
    .i_cs        (bus.cs),
    .o_mosi      (w_mosi),
    .o_cs        (w_cs),
    .o_sclk_rise (w_sclk_rise),
    .o_cs_rise   (w_cs_rise),
    .o_cs_fall   (w_cs_fall)
  );

  assign w_next_cnt = r_bit_cnt + 8'd1;
  assign w_len_ok   = (r_bit_cnt == CNT_FULL);

`ifdef SPI_RX_FRAME_CHECK_EN
  // Reserved bits must be clear and the pointer may not run past the size
  assign w_chk_ok = (r_shadow[SIZE_LSB+7 -: 2] == 2'b00) &&
                    (r_shadow[PTR_LSB+7 -: 2] == 2'b00) &&
                    (r_shadow[LAST_BITS-1 -: 3] == 3'b000) &&
                    (r_shadow[PTR_LSB +: 8] <= r_shadow[SIZE_LSB +: 8]);
`else
  assign w_chk_ok = 1'b1;
`endif

  // Frame FSM: shift bits, track the field being received, commit or reject on cs rise
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= WAIT_IDLE;
      r_bit_cnt     <= '0;
      r_shadow      <= '0;
      r_page        <= '0;
      r_size        <= '0;
      r_ptr         <= '0;
      r_page_sel    <= 1'b0;
      r_answer      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      case (r_state)
        WAIT_IDLE: begin
          if (w_cs) r_state <= IDLE;
        end
        IDLE: begin
          if (w_cs_fall) begin
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= PAGE;
          end
        end
        PAGE, POINTERS, LAST: begin
          // A bit arriving with the cs rise is still taken before the commit
          if (w_sclk_rise) begin
            r_bit_cnt <= w_next_cnt;
            if (w_len_ok) begin
              // Count moves to 193 so the commit sees a bad length
              r_state <= OVERRUN;
            end else begin
              r_shadow <= {r_shadow[FRAME_BITS-2:0], w_mosi};
              if (w_next_cnt < CNT_PAGE)      r_state <= PAGE;
              else if (w_next_cnt < CNT_PTRS) r_state <= POINTERS;
              else                            r_state <= LAST;
            end
          end
          if (w_cs_rise) begin
            r_busy  <= 1'b0;
            r_state <= COMMIT;
          end
        end
        OVERRUN: begin
          if (w_cs_rise) begin
            r_busy  <= 1'b0;
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          if (w_len_ok && w_chk_ok) begin
            for (int i = 0; i < page; i++) begin
              r_page[i] <= r_shadow[FRAME_BITS-1-width*i -: width];
            end
            r_size        <= r_shadow[SIZE_LSB +: PW];
            r_ptr         <= r_shadow[PTR_LSB +: PW];
            r_page_sel    <= r_shadow[newWidth];
            r_answer      <= r_shadow[newWidth-1:0];
            r_frame_valid <= 1'b1;
          end else begin
            r_frame_error <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  assign bus.rxPage     = r_page;
  assign bus.rxSize     = r_size;
  assign bus.rxPtr      = r_ptr;
  assign bus.rxPageSel  = r_page_sel;
  assign bus.rxAnswer   = r_answer;
  assign bus.frameValid = r_frame_valid;
  assign bus.frameError = r_frame_error;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver with a field-level reference model.
// Latency: model expects pulses and output updates 4 clocks after the cs pin rise.
// Backpressure: none; frames are driven with slow sclk phases of 5 clocks.
module tb_spi_frame_receiver;

  localparam int LAT = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  spi_frame_receiver_if bus ();

  spi_frame_receiver dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int n_fv  = 0;
  int n_fe  = 0;
  logic chk_on = 1'b0;

  // Reference model: currently held fields plus one scheduled event
  logic [7:0]   m_page [16];
  logic [5:0]   m_size, m_ptr;
  logic         m_sel;
  logic [43:0]  m_ans;
  int           p_cyc   = -1;
  logic         p_valid = 1'b0;
  logic         p_error = 1'b0;
  logic         p_clear = 1'b0;
  logic [191:0] p_frame = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) m_page[i] = 8'h00;
    m_size = '0; m_ptr = '0; m_sel = 1'b0; m_ans = '0;
  endfunction

  // Fields by wire position: bit n of the frame sits at f[191-n]
  function automatic void model_load(input logic [191:0] f);
    for (int i = 0; i < 16; i++) m_page[i] = f[191-8*i -: 8];
    m_size = f[61:56];
    m_ptr  = f[53:48];
    m_sel  = f[44];
    m_ans  = f[43:0];
  endfunction

  function automatic logic frame_ok(input logic [191:0] f, input int nbits);
    logic ok;
    ok = (nbits == 192);
`ifdef SPI_RX_FRAME_CHECK_EN
    if (f[63:62] != 2'b00 || f[55:54] != 2'b00 || f[47:45] != 3'b000 || f[55:48] > f[63:56])
      ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [191:0] mk_frame(input logic [7:0] start, input logic [7:0] size,
                                            input logic [7:0] ptr, input logic [47:0] last);
    logic [127:0] pg;
    for (int i = 0; i < 16; i++) pg[127-8*i -: 8] = start + 8'(i);
    return {pg, size, ptr, last};
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    logic ev;
    logic [127:0] pk;
    if (chk_on) begin
      ev = (cyc == p_cyc);
      if (ev && p_clear) model_clear();
      if (ev && p_valid) model_load(p_frame);
      for (int i = 0; i < 16; i++) pk[8*i +: 8] = m_page[i];
      check("frameValid", 128'(bus.frameValid), 128'(ev && p_valid));
      check("frameError", 128'(bus.frameError), 128'(ev && p_error));
      check("rxPage",     128'(bus.rxPage), pk);
      check("rxSize",     128'(bus.rxSize), 128'(m_size));
      check("rxPtr",      128'(bus.rxPtr), 128'(m_ptr));
      check("rxPageSel",  128'(bus.rxPageSel), 128'(m_sel));
      check("rxAnswer",   128'(bus.rxAnswer), 128'(m_ans));
      if (bus.frameValid === 1'b1) n_fv++;
      if (bus.frameError === 1'b1) n_fe++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start_frame();
    bus.cs = 1'b0;
    tick(6);
  endtask

  task automatic send_bits(input logic [191:0] f, input int from, input int to);
    for (int n = from; n < to; n++) begin
      if (n < 192) bus.mosi = f[191-n];
      else         bus.mosi = 1'b0;
      tick(5);
      bus.sclk = 1'b1;
      tick(5);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic end_frame(input logic [191:0] f, input int nbits, input logic armed);
    tick(5);
    bus.cs = 1'b1;
    if (armed) begin
      p_frame = f;
      p_valid = frame_ok(f, nbits);
      p_error = !p_valid;
      p_clear = 1'b0;
      p_cyc   = cyc + LAT;
    end
  endtask

  initial begin
    logic [191:0] f;
    int fv0, fe0;
    reset = 1'b0;
    bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    model_clear();
    tick(5);
    check("rst_answer", 128'(bus.rxAnswer), 128'h0);
    check("rst_page",   128'(bus.rxPage), 128'h0);
    check("rst_valid",  128'(bus.frameValid), 128'h0);
    check("rst_error",  128'(bus.frameError), 128'h0);
    check("rst_busy",   128'(bus.busy), 128'h0);
    reset = 1'b1;
    chk_on = 1'b1;
    tick(10);

    // Good frame
    f = mk_frame(8'h00, 8'h0A, 8'h03, {3'b000, 1'b1, 44'h0_0000_0012_3456});
    start_frame();
    send_bits(f, 0, 50);
    check("busy_mid", 128'(bus.busy), 128'h1);
    send_bits(f, 50, 192);
    end_frame(f, 192, 1'b1);
    tick(10);
    check("good_fv_cnt", 128'(n_fv), 128'd1);
    check("good_page5",  128'(bus.rxPage[5]), 128'h05);
    check("good_size",   128'(bus.rxSize), 128'd10);
    check("good_ptr",    128'(bus.rxPtr), 128'd3);
    check("good_sel",    128'(bus.rxPageSel), 128'h1);
    check("good_answer", 128'(bus.rxAnswer), 128'h12_3456);
    check("idle_busy",   128'(bus.busy), 128'h0);

    // Short frame
    f = mk_frame(8'h40, 8'h05, 8'h01, {3'b000, 1'b0, 44'hABC});
    fe0 = n_fe;
    start_frame();
    send_bits(f, 0, 100);
    end_frame(f, 100, 1'b1);
    tick(10);
    check("short_fe_cnt", 128'(n_fe - fe0), 128'd1);
    check("short_answer", 128'(bus.rxAnswer), 128'h12_3456);

    // Overrun
    fe0 = n_fe;
    start_frame();
    send_bits(f, 0, 193);
    end_frame(f, 193, 1'b1);
    tick(10);
    check("ovr_fe_cnt", 128'(n_fe - fe0), 128'd1);
    check("ovr_size",   128'(bus.rxSize), 128'd10);

    // Reset at bit 60, frame continues with cs low
    fv0 = n_fv; fe0 = n_fe;
    start_frame();
    send_bits(f, 0, 60);
    reset = 1'b0;
    p_clear = 1'b1; p_valid = 1'b0; p_error = 1'b0; p_cyc = cyc + 1;
    tick(2);
    reset = 1'b1;
    send_bits(f, 60, 100);
    check("rst_mid_busy", 128'(bus.busy), 128'h0);
    send_bits(f, 100, 192);
    end_frame(f, 192, 1'b0);
    tick(30);
    check("rst_mid_nofv", 128'(n_fv - fv0), 128'd0);
    check("rst_mid_nofe", 128'(n_fe - fe0), 128'd0);
    f = mk_frame(8'h80, 8'h14, 8'h07, {3'b000, 1'b0, 44'hA_BCDE});
    start_frame();
    send_bits(f, 0, 192);
    end_frame(f, 192, 1'b1);
    tick(10);
    check("after_rst_fv", 128'(n_fv - fv0), 128'd1);
    check("after_rst_ans", 128'(bus.rxAnswer), 128'hA_BCDE);

    // Pointer beyond size
    fv0 = n_fv; fe0 = n_fe;
    f = mk_frame(8'h20, 8'h0A, 8'h0B, {3'b000, 1'b0, 44'h777});
    start_frame();
    send_bits(f, 0, 192);
    end_frame(f, 192, 1'b1);
    tick(10);
`ifdef SPI_RX_FRAME_CHECK_EN
    check("ptr_gt_fe",  128'(n_fe - fe0), 128'd1);
    check("ptr_gt_ptr", 128'(bus.rxPtr), 128'd7);
`else
    check("ptr_gt_fv",  128'(n_fv - fv0), 128'd1);
    check("ptr_gt_ptr", 128'(bus.rxPtr), 128'd11);
`endif

    // Reserved bit set in the last field
    f = mk_frame(8'h30, 8'h05, 8'h02, {3'b100, 1'b1, 44'h55});
    start_frame();
    send_bits(f, 0, 192);
    end_frame(f, 192, 1'b1);
    tick(10);
`ifdef SPI_RX_FRAME_CHECK_EN
    check("rsv_answer", 128'(bus.rxAnswer), 128'hA_BCDE);
`else
    check("rsv_answer", 128'(bus.rxAnswer), 128'h55);
`endif

    // Back-to-back with a 2-clock cs-high gap
    fv0 = n_fv;
    f = mk_frame(8'h10, 8'h08, 8'h04, {3'b000, 1'b0, 44'h1});
    start_frame();
    send_bits(f, 0, 192);
    end_frame(f, 192, 1'b1);
    tick(2);
    f = mk_frame(8'h50, 8'h09, 8'h05, {3'b000, 1'b1, 44'h2});
    start_frame();
    send_bits(f, 0, 192);
    end_frame(f, 192, 1'b1);
    tick(10);
    check("b2b_fv_cnt", 128'(n_fv - fv0), 128'd2);
    check("b2b_answer", 128'(bus.rxAnswer), 128'h2);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
